fetch_decode_queue: RTL



---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fetch_decode_queue_if.sv | 28 ++
 rtl/fetch_decode_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the packed fetch/decode queue entry.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t imemload;
        word_t imemaddr;
        word_t next_memaddr;
    } fdq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Bundle of the fetch/decode queue signals (clock and reset excluded) with a block-side and a bench-side view.
interface fetch_decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    logic                     ihit;
    logic [WIDTH-1:0]         imemload;
    logic [WIDTH-1:0]         imemaddr;
    logic [WIDTH-1:0]         next_memaddr;
    logic                     stall;
    logic                     flush;
    logic [WIDTH-1:0]         n1_imemload;
    logic [WIDTH-1:0]         n1_imemaddr;
    logic [WIDTH-1:0]         n1_next_memaddr;
    logic                     n1_valid;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    modport fdq (
        input  ihit, imemload, imemaddr, next_memaddr, stall, flush,
        output n1_imemload, n1_imemaddr, n1_next_memaddr, n1_valid, full, count
    );

    modport tb (
        output ihit, imemload, imemaddr, next_memaddr, stall, flush,
        input  n1_imemload, n1_imemaddr, n1_next_memaddr, n1_valid, full, count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry circular instruction queue between fetch and decode.
// Head outputs come straight from registered state; an empty queue presents a zero (nop) head.
module fetch_decode_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic [WIDTH-1:0]       imemload,
    input  logic [WIDTH-1:0]       imemaddr,
    input  logic [WIDTH-1:0]       next_memaddr,
    input  logic                   stall,
    input  logic                   flush,
    output logic [WIDTH-1:0]       n1_imemload,
    output logic [WIDTH-1:0]       n1_imemaddr,
    output logic [WIDTH-1:0]       n1_next_memaddr,
    output logic                   n1_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] imemload;
        logic [WIDTH-1:0] imemaddr;
        logic [WIDTH-1:0] next_memaddr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;
    logic          push;

    // Handshake: n1_valid acts as valid and ~stall as ready on the decode side (pop = both, no flush);
    // on the fetch side ihit is valid and ~full as ready, except a full queue still accepts when it pops.
    assign n1_valid = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = n1_valid & ~stall & ~flush;
    assign push     = ihit & ~flush & (~full | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {imemload, imemaddr, next_memaddr};
            end
        end
    end

    // Stale storage behind an empty queue must never leak to decode.
    assign head            = n1_valid ? mem_q[rd_ptr_q] : '0;
    assign n1_imemload     = head.imemload;
    assign n1_imemaddr     = head.imemaddr;
    assign n1_next_memaddr = head.next_memaddr;
    assign count           = count_q;

endmodule
